// File: rtl/bsg_bladerunner_cfg_mem_pkg.sv
// Shared definitions for the configuration store: address regions, the
// address decoder and the default scratch depth.
package bsg_bladerunner_cfg_mem_pkg;

    localparam int default_scratch_els_c = 8;

    typedef enum logic [1:0] {
        e_region_rom,
        e_region_scratch,
        e_region_unmapped
    } region_e;

    // Classify a word address; with scratch disabled its window is unmapped.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned rom_els,
                                              input int unsigned scratch_els,
                                              input bit scratch_en);
        if (addr < rom_els) return e_region_rom;
        if (scratch_en && (addr < rom_els + scratch_els)) return e_region_scratch;
        return e_region_unmapped;
    endfunction

endpackage

// File: rtl/bsg_bladerunner_cfg_mem_if.sv
// Request/response bundle between the manycore endpoint and the config store.
// master = requester/consumer side, slave = the config store.
interface bsg_bladerunner_cfg_mem_if #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 8,
    parameter int err_width_p  = 8
);
    logic                      in_v_i;
    logic                      in_yumi_o;
    logic                      in_we_i;
    logic [addr_width_p-1:0]   in_addr_i;
    logic [data_width_p-1:0]   in_data_i;
    logic [data_width_p/8-1:0] in_mask_i;
    logic                      returning_v_o;
    logic [data_width_p-1:0]   returning_data_o;
    logic                      returning_ready_i;
    logic [err_width_p-1:0]    err_count_o;

    modport master (
        output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, returning_ready_i,
        input  in_yumi_o, returning_v_o, returning_data_o, err_count_o
    );

    modport slave (
        input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, returning_ready_i,
        output in_yumi_o, returning_v_o, returning_data_o, err_count_o
    );
endinterface

// File: rtl/bsg_bladerunner_configuration.sv
// Configuration ROM contents: a fixed per-word signature, truncated to width_p.
module bsg_bladerunner_configuration #(
    parameter  int width_p       = 32,
    parameter  int els_p         = 16,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic [addr_width_lp-1:0] addr_i,
    output logic [width_p-1:0]       data_o
);
    assign data_o = width_p'((32'(addr_i) * 32'h9E37_79B1) ^ 32'hB1AD_E000);
endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with valid/yumi dequeue and an occupancy count. The
// producer is expected to check count_o before enqueueing.
module bsg_fifo_1r1w_small #(
    parameter  int width_p        = 32,
    parameter  int els_p          = 2,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);
    logic [width_p-1:0]        mem [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr;
    logic [ptr_width_lp-1:0]   rd_ptr;
    logic [count_width_lp-1:0] count;

    function automatic logic [ptr_width_lp-1:0] bump(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (v_i)    wr_ptr <= bump(wr_ptr);
            if (yumi_i) rd_ptr <= bump(rd_ptr);
            case ({v_i, yumi_i})
                2'b10:   count <= count + count_width_lp'(1);
                2'b01:   count <= count - count_width_lp'(1);
                default: ;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; v_o keeps consumers away from stale words.
        if (v_i) mem[wr_ptr] <= data_i;
    end

    assign v_o     = (count != '0);
    assign data_o  = mem[rd_ptr];
    assign count_o = count;
endmodule

// File: rtl/bsg_bladerunner_cfg_mem.sv
// Memory-mapped configuration store: read-only ROM region plus optional
// byte-masked scratch region, buffered back-pressurable read responses and a
// saturating illegal-access counter.
// Scratch storage is built only when BSG_BLADERUNNER_CFG_MEM_SCRATCH_EN is
// defined; otherwise its window decodes as unmapped.
module bsg_bladerunner_cfg_mem
    import bsg_bladerunner_cfg_mem_pkg::*;
#(
    parameter int rom_width_p    = 32,
    parameter int rom_els_p      = 16,
    parameter int scratch_els_p  = default_scratch_els_c,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 8,
    parameter int ret_fifo_els_p = 2,
    parameter int err_width_p    = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_bladerunner_cfg_mem_if.slave bus
);
    localparam int mask_width_lp     = data_width_p / 8;
    localparam int rom_addr_width_lp = (rom_els_p > 1) ? $clog2(rom_els_p) : 1;
    localparam int count_width_lp    = $clog2(ret_fifo_els_p + 1);
`ifdef BSG_BLADERUNNER_CFG_MEM_SCRATCH_EN
    localparam bit scratch_en_lp = 1'b1;
`else
    localparam bit scratch_en_lp = 1'b0;
`endif

    if (rom_width_p > data_width_p) begin : g_chk_rom_width
        $error("rom_width_p (%0d) exceeds data_width_p (%0d)", rom_width_p, data_width_p);
    end
    if ($clog2(rom_els_p + scratch_els_p) > addr_width_p) begin : g_chk_addr_width
        $error("address map needs more than addr_width_p (%0d) bits", addr_width_p);
    end

    logic [31:0]                  addr_ext;
    region_e                      region;
    logic                         read_room;
    logic                         accept;
    logic                         accept_read;
    logic                         accept_write;
    logic                         illegal;
    logic [rom_addr_width_lp-1:0] rom_addr;
    logic [rom_width_p-1:0]       rom_data;
    logic [data_width_p-1:0]      scratch_rdata;
    logic [data_width_p-1:0]      raw_data;
    logic [data_width_p-1:0]      resp_data;
    logic                         stage_v;
    logic [data_width_p-1:0]      stage_data;
    logic                         bypass;
    logic                         fifo_enq;
    logic                         fifo_deq;
    logic                         fifo_v;
    logic [data_width_p-1:0]      fifo_data;
    logic [count_width_lp-1:0]    fifo_count;
    logic [err_width_p-1:0]       err_count;

    assign addr_ext = 32'(bus.in_addr_i);
    assign region   = decode_region(addr_ext, rom_els_p, scratch_els_p, scratch_en_lp);

    // A read may enter only if the stage register plus the FIFO still leave a
    // free slot, so the stage can always drain into the FIFO next cycle.
    assign read_room    = (32'(fifo_count) + 32'(stage_v)) < 32'(ret_fifo_els_p);
    assign accept       = bus.in_v_i & ~reset_i & (bus.in_we_i | read_room);
    assign accept_read  = accept & ~bus.in_we_i;
    assign accept_write = accept & bus.in_we_i;
    assign illegal      = accept & ((region == e_region_unmapped)
                                  | (bus.in_we_i & (region == e_region_rom)));
    assign bus.in_yumi_o = accept;

    assign rom_addr = addr_ext[rom_addr_width_lp-1:0];

    bsg_bladerunner_configuration #(
        .width_p(rom_width_p),
        .els_p  (rom_els_p)
    ) rom (
        .addr_i(rom_addr),
        .data_o(rom_data)
    );

    // Select the addressed word and apply the byte mask captured with the request.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        raw_data  = '0;
        resp_data = '0;
        unique case (region)
            e_region_rom:     raw_data = data_width_p'(rom_data);
            e_region_scratch: raw_data = scratch_rdata;
            default:          raw_data = '0;
        endcase
        for (int b = 0; b < mask_width_lp; b++) begin
            resp_data[b*8 +: 8] = bus.in_mask_i[b] ? raw_data[b*8 +: 8] : 8'h00;
        end
    end

`ifdef BSG_BLADERUNNER_CFG_MEM_SCRATCH_EN
    logic [31:0]             scratch_offset;
    logic [data_width_p-1:0] scratch_mem [scratch_els_p];

    assign scratch_offset = addr_ext - 32'(rom_els_p);

    // Byte-masked scratch update; software relies on scratch reading zero after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < scratch_els_p; i++) scratch_mem[i] <= '0;
        end else if (accept_write && (region == e_region_scratch)) begin
            for (int i = 0; i < scratch_els_p; i++) begin
                if (scratch_offset == 32'(i)) begin
                    for (int b = 0; b < mask_width_lp; b++) begin
                        if (bus.in_mask_i[b]) scratch_mem[i][b*8 +: 8] <= bus.in_data_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Scratch read mux over the word index.
    always_comb begin
        scratch_rdata = '0;
        for (int i = 0; i < scratch_els_p; i++) begin
            if (scratch_offset == 32'(i)) scratch_rdata = scratch_mem[i];
        end
    end
`else
    assign scratch_rdata = '0;
`endif

    // Single read pipeline register; it empties every cycle, either straight
    // to the consumer or into the FIFO.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_v    <= 1'b0;
            stage_data <= '0;
        end else begin
            stage_v <= accept_read;
            if (accept_read) stage_data <= resp_data;
        end
    end

    // The stage skips the FIFO only when nothing older is queued and the
    // consumer takes it now; this keeps responses in acceptance order.
    assign bypass   = stage_v & ~fifo_v & bus.returning_ready_i;
    assign fifo_enq = stage_v & ~bypass;
    assign fifo_deq = fifo_v & bus.returning_ready_i;

    bsg_fifo_1r1w_small #(
        .width_p(data_width_p),
        .els_p  (ret_fifo_els_p)
    ) ret_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (fifo_enq),
        .data_i (stage_data),
        .v_o    (fifo_v),
        .data_o (fifo_data),
        .yumi_i (fifo_deq),
        .count_o(fifo_count)
    );

    assign bus.returning_v_o    = fifo_v | stage_v;
    assign bus.returning_data_o = fifo_v  ? fifo_data
                                : stage_v ? stage_data
                                :           '0;

    // Saturating illegal-access counter, cleared only by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_count <= '0;
        end else if (illegal && (err_count != {err_width_p{1'b1}})) begin
            err_count <= err_count + err_width_p'(1);
        end
    end

    assign bus.err_count_o = err_count;
endmodule
